phase_sequencer: RTL and testbench

//  Upstream timing stage of the CPU. Generates the one-clock phase strobes X (fetch), Y (stack) and Z (operand).

---
 rtl/phase_sequencer.sv | 121 ++++++++++++
 tb/tb_phase_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// ============================================================================
// Module   : phase_sequencer
// Brief    : CPU phase sequencer. Steps through FETCH/STACK/OPER and emits
//            one-clock X/Y/Z strobes. Supports run/halt, memory-wait stall,
//            programmable phase length and a retired-instruction counter.
//            Optional single-step port enabled by the SEQ_SINGLESTEP_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_sequencer #(
    parameter int PHASE_LEN = 2,
    parameter int CNT_W     = 16
) (
    input  logic             i_CLOCK,
    input  logic             i_RESETN,
    input  logic             i_RUN,
    input  logic             i_HALT,
    input  logic             i_STALL,
`ifdef SEQ_SINGLESTEP_EN
    input  logic             i_STEP,
`endif
    output logic             o_CYCLEX,
    output logic             o_CYCLEY,
    output logic             o_CYCLEZ,
    output logic [1:0]       o_STATE,
    output logic             o_BUSY,
    output logic [CNT_W-1:0] o_INSTRET
);

    localparam int            DW         = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(PHASE_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_STACK = 2'd2,
        S_OPER  = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [DW-1:0]    dwell_q,     dwell_d;
    logic             halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0] instret_q,   instret_d;
    logic             w_strobe;
    logic             w_start;
    logic             w_single;

    // Strobe is a pure AND of registered state and the live stall input.
    assign w_strobe = (state_q != S_IDLE) && (dwell_q == DWELL_LAST) && !i_STALL;

`ifdef SEQ_SINGLESTEP_EN
    assign w_single = i_STEP && !i_HALT;
    assign w_start  = (i_RUN || i_STEP) && !i_HALT;
`else
    assign w_single = 1'b0;
    assign w_start  = i_RUN && !i_HALT;
`endif

    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        halt_pend_d = halt_pend_q;
        instret_d   = instret_q;

        if (state_q == S_IDLE) begin
            dwell_d     = '0;
            halt_pend_d = 1'b0;
            if (w_start) begin
                state_d     = S_FETCH;
                halt_pend_d = w_single;
            end
        end else begin
            if (i_HALT) begin
                halt_pend_d = 1'b1;
            end
            if (w_strobe) begin
                dwell_d = '0;
                if (state_q == S_FETCH) begin
                    state_d = S_STACK;
                end else if (state_q == S_STACK) begin
                    state_d = S_OPER;
                end else begin
                    instret_d = instret_q + CNT_W'(1);
                    if (halt_pend_q || i_HALT) begin
                        state_d     = S_IDLE;
                        halt_pend_d = 1'b0;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end else if (!i_STALL) begin
                dwell_d = dwell_q + DW'(1);
            end
        end
    end

    always_ff @(posedge i_CLOCK or negedge i_RESETN) begin
        if (!i_RESETN) begin
            state_q     <= S_IDLE;
            dwell_q     <= '0;
            halt_pend_q <= 1'b0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            halt_pend_q <= halt_pend_d;
            instret_q   <= instret_d;
        end
    end

    assign o_CYCLEX  = w_strobe && (state_q == S_FETCH);
    assign o_CYCLEY  = w_strobe && (state_q == S_STACK);
    assign o_CYCLEZ  = w_strobe && (state_q == S_OPER);
    assign o_STATE   = state_q;
    assign o_BUSY    = (state_q != S_IDLE);
    assign o_INSTRET = instret_q;

endmodule

`default_nettype wire

// File: tb/tb_phase_sequencer.sv
// ============================================================================
// Module   : tb_phase_sequencer
// Brief    : Directed vector bench for phase_sequencer (PHASE_LEN=2/CNT_W=16
//            instance plus a PHASE_LEN=1/CNT_W=4 instance for counter wrap).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phase_sequencer;

    typedef struct packed {
        logic       run;
        logic       halt;
        logic       stall;
        logic [1:0] st;
        logic       x;
        logic       y;
        logic       z;
        logic [15:0] ir;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn, run, halt, stall;
    logic        x, y, z, busy;
    logic [1:0]  st;
    logic [15:0] ir;

    logic        rst4n, run4, halt4, stall4;
    logic        x4, y4, z4, busy4;
    logic [1:0]  st4;
    logic [3:0]  ir4;

`ifdef SEQ_SINGLESTEP_EN
    logic        step;
    logic        step4;
`endif

    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    phase_sequencer dut (
        .i_CLOCK   (clk),
        .i_RESETN  (rstn),
        .i_RUN     (run),
        .i_HALT    (halt),
        .i_STALL   (stall),
`ifdef SEQ_SINGLESTEP_EN
        .i_STEP    (step),
`endif
        .o_CYCLEX  (x),
        .o_CYCLEY  (y),
        .o_CYCLEZ  (z),
        .o_STATE   (st),
        .o_BUSY    (busy),
        .o_INSTRET (ir)
    );

    phase_sequencer #(.PHASE_LEN(1), .CNT_W(4)) dut4 (
        .i_CLOCK   (clk),
        .i_RESETN  (rst4n),
        .i_RUN     (run4),
        .i_HALT    (halt4),
        .i_STALL   (stall4),
`ifdef SEQ_SINGLESTEP_EN
        .i_STEP    (step4),
`endif
        .o_CYCLEX  (x4),
        .o_CYCLEY  (y4),
        .o_CYCLEZ  (z4),
        .o_STATE   (st4),
        .o_BUSY    (busy4),
        .o_INSTRET (ir4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic h, input logic s, input logic [1:0] es,
                       input logic ex, input logic ey, input logic ez, input logic [15:0] ei);
        vec_t v;
        v = '{run: r, halt: h, stall: s, st: es, x: ex, y: ey, z: ez, ir: ei};
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cx, cy, cz;
        int ph;
        rstn = 1'b1; run = 1'b0; halt = 1'b0; stall = 1'b0;
        rst4n = 1'b1; run4 = 1'b0; halt4 = 1'b0; stall4 = 1'b0;
`ifdef SEQ_SINGLESTEP_EN
        step = 1'b0; step4 = 1'b0;
`endif

        // run, halt, stall | state, X, Y, Z, instret
        add(1,0,0, 0,0,0,0, 0); add(1,0,0, 1,0,0,0, 0); add(1,0,0, 1,1,0,0, 0);
        add(1,0,0, 2,0,0,0, 0); add(1,0,0, 2,0,1,0, 0); add(1,0,0, 3,0,0,0, 0);
        add(1,0,0, 3,0,0,1, 0); add(1,0,0, 1,0,0,0, 1); add(1,0,0, 1,1,0,0, 1);
        add(1,0,0, 2,0,0,0, 1); add(1,0,1, 2,0,0,0, 1); add(1,0,1, 2,0,0,0, 1);
        add(1,0,1, 2,0,0,0, 1); add(1,0,0, 2,0,1,0, 1); add(1,0,0, 3,0,0,0, 1);
        add(1,0,0, 3,0,0,1, 1); add(0,1,0, 1,0,0,0, 2); add(0,0,0, 1,1,0,0, 2);
        add(0,0,0, 2,0,0,0, 2); add(0,0,0, 2,0,1,0, 2); add(0,0,0, 3,0,0,0, 2);
        add(0,0,0, 3,0,0,1, 2); add(1,1,0, 0,0,0,0, 3); add(1,1,0, 0,0,0,0, 3);
        add(0,0,0, 0,0,0,0, 3); add(1,0,1, 0,0,0,0, 3); add(0,0,0, 1,0,0,0, 3);
        add(0,0,0, 1,1,0,0, 3); add(0,0,0, 2,0,0,0, 3); add(0,0,0, 2,0,1,0, 3);
        add(0,0,0, 3,0,0,0, 3); add(0,1,0, 3,0,0,1, 3); add(0,1,0, 0,0,0,0, 4);
        add(1,0,0, 0,0,0,0, 4); add(0,0,0, 1,0,0,0, 4); add(0,0,0, 1,1,0,0, 4);
        add(0,0,0, 2,0,0,0, 4); add(0,0,0, 2,0,1,0, 4); add(0,0,0, 3,0,0,0, 4);
        add(0,0,0, 3,0,0,1, 4); add(0,1,0, 1,0,0,0, 5); add(0,0,0, 1,1,0,0, 5);
        add(0,0,0, 2,0,0,0, 5); add(0,0,0, 2,0,1,0, 5); add(0,0,0, 3,0,0,0, 5);
        add(0,0,0, 3,0,0,1, 5); add(0,0,0, 0,0,0,0, 6);

        #2;
        rstn = 1'b0; rst4n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {30'd0, st}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_xyz", {29'd0, x, y, z}, 0);
        chk("reset_instret", {16'd0, ir}, 0);

        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("idle_hold[%0d]", i), {30'd0, st}, 0);
            chk($sformatf("idle_busy[%0d]", i), {31'd0, busy}, 0);
            tick();
        end

        for (int i = 0; i < tbl.size(); i++) begin
            run = tbl[i].run; halt = tbl[i].halt; stall = tbl[i].stall;
            @(negedge clk);
            chk($sformatf("vec%0d_state", i), {30'd0, st}, {30'd0, tbl[i].st});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, (tbl[i].st != 2'd0)});
            chk($sformatf("vec%0d_xyz", i), {29'd0, x, y, z}, {29'd0, tbl[i].x, tbl[i].y, tbl[i].z});
            chk($sformatf("vec%0d_instret", i), {16'd0, ir}, {16'd0, tbl[i].ir});
            tick();
        end
        run = 1'b0; halt = 1'b0; stall = 1'b0;

        // Asynchronous reset while Y is asserted mid-STACK
        run = 1'b1;
        tick();
        run = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("pre_reset_state", {30'd0, st}, 2);
        chk("pre_reset_y", {31'd0, y}, 1);
        #1;
        rstn = 1'b0;
        #1;
        chk("async_reset_state", {30'd0, st}, 0);
        chk("async_reset_xyz", {29'd0, x, y, z}, 0);
        chk("async_reset_busy", {31'd0, busy}, 0);
        chk("async_reset_instret", {16'd0, ir}, 0);
        tick();
        rstn = 1'b1;
        tick();

`ifdef SEQ_SINGLESTEP_EN
        cx = 0; cy = 0; cz = 0;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            cx += int'(x); cy += int'(y); cz += int'(z);
            tick();
        end
        @(negedge clk);
        chk("step_x_count", cx, 1);
        chk("step_y_count", cy, 1);
        chk("step_z_count", cz, 1);
        chk("step_end_state", {30'd0, st}, 0);
        chk("step_instret", {16'd0, ir}, 1);
        tick();

        step = 1'b1; halt = 1'b1;
        tick();
        step = 1'b0; halt = 1'b0;
        @(negedge clk);
        chk("step_blocked_by_halt", {30'd0, st}, 0);
        tick();

        step = 1'b1; run = 1'b1;
        tick();
        step = 1'b0; run = 1'b0;
        repeat (9) tick();
        @(negedge clk);
        chk("step_run_end_state", {30'd0, st}, 0);
        chk("step_run_instret", {16'd0, ir}, 2);
        tick();
`endif

        // PHASE_LEN=1 instance: strobe every cycle, 4-bit counter wraps on 16th Z
        rst4n = 1'b1;
        run4 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("p1_start_state", {30'd0, st4}, 0);
                chk("p1_start_instret", {28'd0, ir4}, 0);
            end else begin
                ph = (i - 1) % 3;
                chk($sformatf("p1_c%0d_state", i), {30'd0, st4}, ph + 1);
                chk($sformatf("p1_c%0d_xyz", i), {29'd0, x4, y4, z4},
                    {29'd0, (ph == 0), (ph == 1), (ph == 2)});
                chk($sformatf("p1_c%0d_instret", i), {28'd0, ir4}, ((i - 1) / 3) % 16);
            end
            tick();
        end
        run4 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
